// File: rtl/flit_packer.sv
// flit_packer: AXI4-Stream packet generator. Turns a (length, seed) command
// into a stream of TDATA_WIDTH flits carrying an incrementing byte pattern,
// with a low-aligned tkeep and tlast on the final flit.
module flit_packer #(
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [7:0]             cmd_seed,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   busy,
  output logic                   zero_len_drop,
  output logic [31:0]            pkt_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                 state_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [7:0]             off_q;
  logic [TDATA_WIDTH-1:0] tdata_q;
  logic [TKEEP_WIDTH-1:0] tkeep_q;
  logic                   tlast_q;
  logic                   tvalid_q;
  logic                   busy_q;
  logic                   cmd_ready_q;
  logic                   zero_drop_q;
  logic [31:0]            pkt_count_q;

  logic [LEN_WIDTH-1:0]   rem_d;
  logic [7:0]             off_d;
  logic [TDATA_WIDTH-1:0] tdata_d;
  logic [TKEEP_WIDTH-1:0] tkeep_d;
  logic                   tlast_d;

  // Remaining count / byte offset of the flit to load next, and that flit's contents.
  // The final flit never subtracts, so the count cannot underflow.
  always_comb begin
    if (state_q == IDLE) begin
      rem_d = cmd_len;
      off_d = cmd_seed;
    end else if (tlast_q) begin
      rem_d = '0;
      off_d = off_q;
    end else begin
      rem_d = rem_q - LEN_WIDTH'(TKEEP_WIDTH);
      off_d = off_q + 8'(TKEEP_WIDTH);
    end
    tdata_d = '0;
    tkeep_d = '0;
    for (int unsigned k = 0; k < TKEEP_WIDTH; k++) begin
      if (rem_d > LEN_WIDTH'(k)) begin
        tkeep_d[k]        = 1'b1;
        tdata_d[8*k +: 8] = off_d + 8'(k);
      end
    end
    tlast_d = (rem_d <= LEN_WIDTH'(TKEEP_WIDTH));
  end

  // Control FSM with registered stream and status outputs.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      off_q       <= '0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      zero_drop_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      zero_drop_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            if (cmd_len == '0) begin
              zero_drop_q <= 1'b1;
            end else begin
              state_q     <= SEND;
              rem_q       <= rem_d;
              off_q       <= off_d;
              tdata_q     <= tdata_d;
              tkeep_q     <= tkeep_d;
              tlast_q     <= tlast_d;
              tvalid_q    <= 1'b1;
              busy_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
            end
          end
        end
        SEND: begin
          if (m_axis_tready) begin
            if (tlast_q) begin
              state_q     <= IDLE;
              tdata_q     <= '0;
              tkeep_q     <= '0;
              tlast_q     <= 1'b0;
              tvalid_q    <= 1'b0;
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              pkt_count_q <= pkt_count_q + 32'd1;
            end else begin
              rem_q   <= rem_d;
              off_q   <= off_d;
              tdata_q <= tdata_d;
              tkeep_q <= tkeep_d;
              tlast_q <= tlast_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign zero_len_drop = zero_drop_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_flit_packer.sv
// tb_flit_packer: directed bench for flit_packer with a 32-bit stream.
`timescale 1ns/1ps
module tb_flit_packer;

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_seed;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        busy;
  logic        zero_len_drop;
  logic [31:0] pkt_count;

  int n_cmp = 0;
  int n_err = 0;

  flit_packer dut (
    .clk           (clk),
    .areset        (areset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_seed      (cmd_seed),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .zero_len_drop (zero_len_drop),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one clock.
  task automatic send_cmd(input logic [15:0] len, input logic [7:0] seed);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_seed  = seed;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    cmd_valid = 1'b0; cmd_len = '0; cmd_seed = '0; m_axis_tready = 1'b1;
    tick(); tick();
    areset = 1'b0;
    tick();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_tvalid got %b exp 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== 32'h0) begin n_err++; $display("FAIL rst_tdata got %h exp 0", m_axis_tdata); end
    n_cmp++; if (m_axis_tkeep !== 4'h0) begin n_err++; $display("FAIL rst_tkeep got %h exp 0", m_axis_tkeep); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL rst_tlast got %b exp 0", m_axis_tlast); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (zero_len_drop !== 1'b0) begin n_err++; $display("FAIL rst_zdrop got %b exp 0", zero_len_drop); end
    n_cmp++; if (pkt_count !== 32'd0) begin n_err++; $display("FAIL rst_pkt_count got %0d exp 0", pkt_count); end
  endtask

  task automatic test_single_flit();
    m_axis_tready = 1'b1;
    send_cmd(16'd4, 8'h10);
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL t1_tvalid got %b exp 1", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== 32'h13121110) begin n_err++; $display("FAIL t1_tdata got %h exp 13121110", m_axis_tdata); end
    n_cmp++; if (m_axis_tkeep !== 4'hF) begin n_err++; $display("FAIL t1_tkeep got %h exp f", m_axis_tkeep); end
    n_cmp++; if (m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL t1_tlast got %b exp 1", m_axis_tlast); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL t1_busy got %b exp 1", busy); end
    n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL t1_cmd_ready_send got %b exp 0", cmd_ready); end
    tick();
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL t1_tvalid_end got %b exp 0", m_axis_tvalid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL t1_cmd_ready_end got %b exp 1", cmd_ready); end
    n_cmp++; if (pkt_count !== 32'd1) begin n_err++; $display("FAIL t1_pkt_count got %0d exp 1", pkt_count); end
  endtask

  task automatic test_two_flits();
    m_axis_tready = 1'b1;
    send_cmd(16'd7, 8'h00);
    // Commands offered during SEND must be ignored.
    cmd_valid = 1'b1; cmd_len = 16'd0; cmd_seed = 8'hAA;
    n_cmp++; if (m_axis_tdata !== 32'h03020100) begin n_err++; $display("FAIL t2_f0_tdata got %h exp 03020100", m_axis_tdata); end
    n_cmp++; if (m_axis_tkeep !== 4'hF) begin n_err++; $display("FAIL t2_f0_tkeep got %h exp f", m_axis_tkeep); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_err++; $display("FAIL t2_f0_tlast got %b exp 0", m_axis_tlast); end
    tick();
    cmd_valid = 1'b0;
    n_cmp++; if (m_axis_tvalid !== 1'b1) begin n_err++; $display("FAIL t2_no_bubble got %b exp 1", m_axis_tvalid); end
    n_cmp++; if (m_axis_tdata !== 32'h00060504) begin n_err++; $display("FAIL t2_f1_tdata got %h exp 00060504", m_axis_tdata); end
    n_cmp++; if (m_axis_tkeep !== 4'h7) begin n_err++; $display("FAIL t2_f1_tkeep got %h exp 7", m_axis_tkeep); end
    n_cmp++; if (m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL t2_f1_tlast got %b exp 1", m_axis_tlast); end
    n_cmp++; if (zero_len_drop !== 1'b0) begin n_err++; $display("FAIL t2_cmd_ignored got %b exp 0", zero_len_drop); end
    tick();
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL t2_tvalid_end got %b exp 0", m_axis_tvalid); end
    n_cmp++; if (pkt_count !== 32'd2) begin n_err++; $display("FAIL t2_pkt_count got %0d exp 2", pkt_count); end
  endtask

  task automatic test_backpressure();
    m_axis_tready = 1'b0;
    send_cmd(16'd5, 8'h20);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (m_axis_tdata !== 32'h23222120 || m_axis_tkeep !== 4'hF || m_axis_tlast !== 1'b0 || m_axis_tvalid !== 1'b1)
        begin n_err++; $display("FAIL t3_f0_hold%0d got %h/%h/%b/%b exp 23222120/f/0/1", i, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid); end
      tick();
    end
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (m_axis_tdata !== 32'h00000024 || m_axis_tkeep !== 4'h1 || m_axis_tlast !== 1'b1 || m_axis_tvalid !== 1'b1)
        begin n_err++; $display("FAIL t3_f1_hold%0d got %h/%h/%b/%b exp 00000024/1/1/1", i, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid); end
      tick();
    end
    n_cmp++; if (pkt_count !== 32'd2) begin n_err++; $display("FAIL t3_pkt_count_stall got %0d exp 2", pkt_count); end
    m_axis_tready = 1'b1;
    tick();
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL t3_tvalid_end got %b exp 0", m_axis_tvalid); end
    n_cmp++; if (pkt_count !== 32'd3) begin n_err++; $display("FAIL t3_pkt_count got %0d exp 3", pkt_count); end
  endtask

  task automatic test_zero_len();
    send_cmd(16'd0, 8'h33);
    n_cmp++; if (zero_len_drop !== 1'b1) begin n_err++; $display("FAIL t4_zdrop got %b exp 1", zero_len_drop); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL t4_tvalid got %b exp 0", m_axis_tvalid); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL t4_cmd_ready got %b exp 1", cmd_ready); end
    tick();
    n_cmp++; if (zero_len_drop !== 1'b0) begin n_err++; $display("FAIL t4_zdrop_pulse got %b exp 0", zero_len_drop); end
    n_cmp++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t4_idle got tvalid %b busy %b exp 0 0", m_axis_tvalid, busy); end
    n_cmp++; if (pkt_count !== 32'd3) begin n_err++; $display("FAIL t4_pkt_count got %0d exp 3", pkt_count); end
  endtask

  task automatic test_wrap();
    m_axis_tready = 1'b1;
    send_cmd(16'd3, 8'hFE);
    n_cmp++; if (m_axis_tdata !== 32'h0000FFFE) begin n_err++; $display("FAIL t5_tdata got %h exp 0000fffe", m_axis_tdata); end
    n_cmp++; if (m_axis_tkeep !== 4'h7 || m_axis_tlast !== 1'b1) begin n_err++; $display("FAIL t5_tkeep_tlast got %h/%b exp 7/1", m_axis_tkeep, m_axis_tlast); end
    tick();
    send_cmd(16'd1, 8'h55);
    n_cmp++; if (m_axis_tdata !== 32'h00000055 || m_axis_tkeep !== 4'h1 || m_axis_tlast !== 1'b1)
      begin n_err++; $display("FAIL t5_len1 got %h/%h/%b exp 00000055/1/1", m_axis_tdata, m_axis_tkeep, m_axis_tlast); end
    tick();
    // Wrap across a flit boundary with an exact multiple of the flit size.
    send_cmd(16'd8, 8'hFC);
    n_cmp++; if (m_axis_tdata !== 32'hFFFEFDFC || m_axis_tkeep !== 4'hF || m_axis_tlast !== 1'b0)
      begin n_err++; $display("FAIL t5_wrap_f0 got %h/%h/%b exp fffefdfc/f/0", m_axis_tdata, m_axis_tkeep, m_axis_tlast); end
    tick();
    n_cmp++; if (m_axis_tdata !== 32'h03020100 || m_axis_tkeep !== 4'hF || m_axis_tlast !== 1'b1)
      begin n_err++; $display("FAIL t5_wrap_f1 got %h/%h/%b exp 03020100/f/1", m_axis_tdata, m_axis_tkeep, m_axis_tlast); end
    tick();
    n_cmp++; if (pkt_count !== 32'd6) begin n_err++; $display("FAIL t5_pkt_count got %0d exp 6", pkt_count); end
  endtask

  task automatic test_reset_mid_packet();
    m_axis_tready = 1'b0;
    send_cmd(16'd12, 8'h40);
    n_cmp++; if (m_axis_tdata !== 32'h43424140 || m_axis_tvalid !== 1'b1)
      begin n_err++; $display("FAIL t6_f0 got %h/%b exp 43424140/1", m_axis_tdata, m_axis_tvalid); end
    areset = 1'b1;
    #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL t6_async got tvalid %b busy %b exp 0 0", m_axis_tvalid, busy); end
    n_cmp++; if (pkt_count !== 32'd0) begin n_err++; $display("FAIL t6_pkt_count got %0d exp 0", pkt_count); end
    tick();
    areset = 1'b0;
    tick();
    n_cmp++; if (cmd_ready !== 1'b1 || m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL t6_after got ready %b tvalid %b exp 1 0", cmd_ready, m_axis_tvalid); end
    m_axis_tready = 1'b1;
    send_cmd(16'd4, 8'h80);
    n_cmp++; if (m_axis_tdata !== 32'h83828180 || m_axis_tkeep !== 4'hF || m_axis_tlast !== 1'b1)
      begin n_err++; $display("FAIL t6_new_pkt got %h/%h/%b exp 83828180/f/1", m_axis_tdata, m_axis_tkeep, m_axis_tlast); end
    tick();
    n_cmp++; if (pkt_count !== 32'd1) begin n_err++; $display("FAIL t6_new_count got %0d exp 1", pkt_count); end
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_two_flits();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
